sprite_layer_compositor: RTL and testbench

Per-pixel layer compositor sitting directly downstream of the palette lookups. It takes the 12-bit RGB outputs of the background, player/Pokémon and pokeball palettes and drops chroma-key (12'hE1E) pixels as transparent. It picks the top opaque layer by fixed priority, applies a frame-stepped fade-to-black/fade-in screen transition, and drives the registered 4-bit-per-channel VGA colour outputs.

---
 rtl/sprite_layer_compositor_pkg.sv | 26 ++
 rtl/sprite_layer_compositor_if.sv | 33 +++
 rtl/sprite_layer_compositor_fade_ctrl.sv | 116 +++++++++++
 rtl/sprite_layer_compositor.sv | 82 ++++++++
 tb/tb_sprite_layer_compositor.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sprite_layer_compositor_pkg.sv
// rtl/sprite_layer_compositor_pkg.sv - shared types, constants and helpers for the sprite layer compositor
package compositor_pkg;

    localparam logic [11:0] KEY_COLOR = 12'hE1E;
    localparam logic [4:0]  FADE_FULL = 5'd16;

    typedef logic [11:0] rgb12_t;

    typedef enum logic [1:0] {
        IDLE,
        FADE_OUT,
        BLACK,
        FADE_IN
    } fade_state_t;

    // A layer covers the pixel only inside its box and off the chroma key.
    function automatic logic is_opaque(input logic hit, input rgb12_t rgb);
        return hit && (rgb != KEY_COLOR);
    endfunction

    // (c * level) >> 4 on a 9-bit product; level 16 is identity, 0 is black.
    function automatic logic [3:0] scale_chan(input logic [3:0] c, input logic [4:0] level);
        return 4'(({5'b0, c} * {4'b0, level}) >> 4);
    endfunction

endpackage

// File: rtl/sprite_layer_compositor_if.sv
// rtl/sprite_layer_compositor_if.sv - pixel, layer, fade control and colour output bundle
interface sprite_layer_compositor_if;
    import compositor_pkg::*;

    logic       blank;
    logic       frame_tick;
    rgb12_t     bg_rgb;
    rgb12_t     opp_rgb;
    logic       opp_hit;
    rgb12_t     plr_rgb;
    logic       plr_hit;
    rgb12_t     ball_rgb;
    logic       ball_hit;
    logic       fade_req;
    logic [3:0] red;
    logic [3:0] green;
    logic [3:0] blue;
    logic       fade_busy;
    logic       scene_swap;

    modport master (
        output blank, frame_tick, bg_rgb, opp_rgb, opp_hit, plr_rgb, plr_hit,
               ball_rgb, ball_hit, fade_req,
        input  red, green, blue, fade_busy, scene_swap
    );

    modport slave (
        input  blank, frame_tick, bg_rgb, opp_rgb, opp_hit, plr_rgb, plr_hit,
               ball_rgb, ball_hit, fade_req,
        output red, green, blue, fade_busy, scene_swap
    );

endinterface

// File: rtl/sprite_layer_compositor_fade_ctrl.sv
// rtl/sprite_layer_compositor_fade_ctrl.sv - fade-out / hold black / fade-in transition FSM with step and hold counters
module fade_ctrl
    import compositor_pkg::*;
#(
    parameter int FRAMES_PER_STEP = 2,
    parameter int HOLD_FRAMES     = 8
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_tick,
    input  logic       fade_req,
    output logic [4:0] level,
    output logic       fade_busy,
    output logic       scene_swap
);

    localparam logic [3:0] STEP_LAST = 4'(FRAMES_PER_STEP - 1);
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_FRAMES - 1);

    fade_state_t state_q, state_d;
    logic [4:0]  level_q, level_d;
    logic [3:0]  step_q, step_d;
    logic [7:0]  hold_q, hold_d;
    logic        busy_q;
    logic        swap_q, swap_d;

    // State, level and counter registers; busy/swap are registered copies of the next-state view.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            level_q <= FADE_FULL;
            step_q  <= '0;
            hold_q  <= '0;
            busy_q  <= 1'b0;
            swap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            step_q  <= step_d;
            hold_q  <= hold_d;
            busy_q  <= (state_d != IDLE);
            swap_q  <= swap_d;
        end
    end

    // Next-state logic: level moves only on frame_tick, counters clear on every state change.
    always_comb begin
        state_d = state_q;
        level_d = level_q;
        step_d  = step_q;
        hold_d  = hold_q;
        swap_d  = 1'b0;
        case (state_q)
            IDLE: begin
                level_d = FADE_FULL;
                if (fade_req) begin
                    state_d = FADE_OUT;
                    step_d  = '0;
                    hold_d  = '0;
                end
            end
            FADE_OUT: begin
                if (frame_tick) begin
                    if (step_q == STEP_LAST) begin
                        step_d  = '0;
                        level_d = (level_q == 5'd0) ? 5'd0 : level_q - 5'd1;
                        if (level_d == 5'd0) begin
                            state_d = BLACK;
                            hold_d  = '0;
                            swap_d  = 1'b1;
                        end
                    end else begin
                        step_d = step_q + 4'd1;
                    end
                end
            end
            BLACK: begin
                level_d = 5'd0;
                if (frame_tick) begin
                    if (hold_q == HOLD_LAST) begin
                        state_d = FADE_IN;
                        hold_d  = '0;
                        step_d  = '0;
                    end else begin
                        hold_d = hold_q + 8'd1;
                    end
                end
            end
            FADE_IN: begin
                if (frame_tick) begin
                    if (step_q == STEP_LAST) begin
                        step_d  = '0;
                        level_d = (level_q >= FADE_FULL) ? FADE_FULL : level_q + 5'd1;
                        if (level_d == FADE_FULL) begin
                            state_d = IDLE;
                            hold_d  = '0;
                        end
                    end else begin
                        step_d = step_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                level_d = FADE_FULL;
                step_d  = '0;
                hold_d  = '0;
            end
        endcase
    end

    assign level      = level_q;
    assign fade_busy  = busy_q;
    assign scene_swap = swap_q;

endmodule

// File: rtl/sprite_layer_compositor.sv
// rtl/sprite_layer_compositor.sv - layer select, 2-stage fade/blank pipeline, VGA colour out (SPRITE_COMPOSITOR_FADE_EN enables fade)
module sprite_layer_compositor
    import compositor_pkg::*;
#(
    parameter int FRAMES_PER_STEP = 2,
    parameter int HOLD_FRAMES     = 8
) (
    input  logic                       Clk,
    input  logic                       Reset,
    sprite_layer_compositor_if.slave   bus
);

    rgb12_t     sel_d;
    rgb12_t     sel_q;
    logic       blank_q;
    rgb12_t     out_d;
    rgb12_t     out_q;
    logic [4:0] level;

`ifdef SPRITE_COMPOSITOR_FADE_EN
    fade_ctrl #(
        .FRAMES_PER_STEP (FRAMES_PER_STEP),
        .HOLD_FRAMES     (HOLD_FRAMES)
    ) u_fade_ctrl (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_tick (bus.frame_tick),
        .fade_req   (bus.fade_req),
        .level      (level),
        .fade_busy  (bus.fade_busy),
        .scene_swap (bus.scene_swap)
    );
`else
    logic unused_fade_inputs;
    assign unused_fade_inputs = bus.frame_tick ^ bus.fade_req;
    assign level              = FADE_FULL;
    assign bus.fade_busy      = 1'b0;
    assign bus.scene_swap     = 1'b0;
`endif

    // Topmost opaque layer wins; evaluated lowest priority first so later hits override.
    always_comb begin
        sel_d = bus.bg_rgb;
        if (is_opaque(bus.opp_hit, bus.opp_rgb)) begin
            sel_d = bus.opp_rgb;
        end
        if (is_opaque(bus.plr_hit, bus.plr_rgb)) begin
            sel_d = bus.plr_rgb;
        end
        if (is_opaque(bus.ball_hit, bus.ball_rgb)) begin
            sel_d = bus.ball_rgb;
        end
    end

    // Scale each channel by the current fade level; blanked pixels are forced black.
    always_comb begin
        out_d = '0;
        if (blank_q) begin
            out_d = {scale_chan(sel_q[11:8], level),
                     scale_chan(sel_q[7:4],  level),
                     scale_chan(sel_q[3:0],  level)};
        end
    end

    // Stage 1 holds the selected colour and blank; stage 2 holds the final pixel.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sel_q   <= '0;
            blank_q <= 1'b0;
            out_q   <= '0;
        end else begin
            sel_q   <= sel_d;
            blank_q <= bus.blank;
            out_q   <= out_d;
        end
    end

    assign bus.red   = out_q[11:8];
    assign bus.green = out_q[7:4];
    assign bus.blue  = out_q[3:0];

endmodule

// File: tb/tb_sprite_layer_compositor.sv
// tb/tb_sprite_layer_compositor.sv - self-checking bench for sprite_layer_compositor
module tb_sprite_layer_compositor;

    localparam int FPS   = 2;
    localparam int HOLD  = 3;
    localparam int OUTN  = 16 * FPS;
    localparam int TOTAL = 2 * 16 * FPS + HOLD;
`ifdef SPRITE_COMPOSITOR_FADE_EN
    localparam bit FADE_EN = 1'b1;
`else
    localparam bit FADE_EN = 1'b0;
`endif

    logic Clk;
    logic Reset;
    int   vectors;
    int   miscompares;
    int   swap_cnt;

    sprite_layer_compositor_if bus ();

    sprite_layer_compositor #(
        .FRAMES_PER_STEP (FPS),
        .HOLD_FRAMES     (HOLD)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    // ---------------- behavioural model ----------------
    logic        m_active;
    int          m_t;
    logic [11:0] m_s1_sel;
    logic        m_s1_blank;
    logic [11:0] m_out;
    logic        m_swap;

    function automatic int model_level(input logic active, input int t);
        if (!active)           return 16;
        if (t < OUTN)          return 16 - t / FPS;
        if (t < OUTN + HOLD)   return 0;
        return (t - OUTN - HOLD) / FPS;
    endfunction

    function automatic logic [11:0] pick(input logic [11:0] bg,
                                         input logic oh, input logic [11:0] o,
                                         input logic ph, input logic [11:0] p,
                                         input logic bh, input logic [11:0] b);
        logic [11:0] key;
        key = 12'hE1E;
        if (bh && b != key) return b;
        if (ph && p != key) return p;
        if (oh && o != key) return o;
        return bg;
    endfunction

    function automatic logic [11:0] fade_px(input logic [11:0] px, input int l);
        int r, g, b;
        r = int'(px[11:8]) * l / 16;
        g = int'(px[7:4]) * l / 16;
        b = int'(px[3:0]) * l / 16;
        return {4'(r), 4'(g), 4'(b)};
    endfunction

    always @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            m_active   <= 1'b0;
            m_t        <= 0;
            m_s1_sel   <= '0;
            m_s1_blank <= 1'b0;
            m_out      <= '0;
            m_swap     <= 1'b0;
        end else begin
            m_out      <= m_s1_blank ? fade_px(m_s1_sel, model_level(m_active, m_t)) : 12'h000;
            m_s1_sel   <= pick(bus.bg_rgb, bus.opp_hit, bus.opp_rgb, bus.plr_hit, bus.plr_rgb,
                               bus.ball_hit, bus.ball_rgb);
            m_s1_blank <= bus.blank;
            m_swap     <= 1'b0;
            if (FADE_EN) begin
                if (!m_active) begin
                    if (bus.fade_req) begin
                        m_active <= 1'b1;
                        m_t      <= 0;
                    end
                end else if (bus.frame_tick) begin
                    m_t    <= m_t + 1;
                    m_swap <= (m_t + 1 == OUTN);
                    if (m_t + 1 == TOTAL) m_active <= 1'b0;
                end
            end
        end
    end

    task automatic check(input string name, input logic [11:0] got, input logic [11:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the rising edge.
    always @(negedge Clk) begin
        if (!Reset) begin
            check("pixel", {bus.red, bus.green, bus.blue}, m_out);
            check("fade_busy", 12'(bus.fade_busy), 12'(m_active));
            check("scene_swap", 12'(bus.scene_swap), 12'(m_swap));
            if (bus.scene_swap) swap_cnt++;
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            bus.frame_tick = 1'b1;
            cyc(1);
            bus.frame_tick = 1'b0;
            cyc(2);
        end
    endtask

    task automatic pulse_req();
        bus.fade_req = 1'b1;
        cyc(1);
        bus.fade_req = 1'b0;
    endtask

    function automatic logic [11:0] fx(input logic [11:0] with_fade, input logic [11:0] without);
        return FADE_EN ? with_fade : without;
    endfunction

    function automatic logic [11:0] pix();
        return {bus.red, bus.green, bus.blue};
    endfunction

    initial begin
        vectors     = 0;
        miscompares = 0;
        swap_cnt    = 0;
        Clk         = 1'b0;
        Reset       = 1'b1;
        bus.blank      = 1'b1;
        bus.frame_tick = 1'b0;
        bus.fade_req   = 1'b0;
        bus.bg_rgb     = 12'h000;
        bus.opp_rgb    = 12'h000;
        bus.opp_hit    = 1'b0;
        bus.plr_rgb    = 12'h000;
        bus.plr_hit    = 1'b0;
        bus.ball_rgb   = 12'h000;
        bus.ball_hit   = 1'b0;

        cyc(3);
        check("reset_pixel", pix(), 12'h000);
        check("reset_busy", 12'(bus.fade_busy), 12'h000);
        check("reset_swap", 12'(bus.scene_swap), 12'h000);
        Reset = 1'b0;
        cyc(1);

        bus.bg_rgb   = 12'h123;
        bus.opp_rgb  = 12'h789;
        bus.plr_rgb  = 12'h456;
        bus.plr_hit  = 1'b1;
        bus.ball_rgb = 12'hE1E;
        bus.ball_hit = 1'b1;
        cyc(2);
        check("prio_player_over_keyed_ball", pix(), 12'h456);
        bus.plr_rgb = 12'hE1E;
        cyc(2);
        check("prio_all_keyed_bg", pix(), 12'h123);
        bus.opp_hit = 1'b1;
        cyc(2);
        check("prio_opponent", pix(), 12'h789);
        bus.ball_rgb = 12'h0F0;
        cyc(2);
        check("prio_ball_top", pix(), 12'h0F0);

        bus.opp_hit  = 1'b0;
        bus.plr_hit  = 1'b0;
        bus.ball_hit = 1'b0;
        bus.bg_rgb   = 12'hFFF;
        bus.blank    = 1'b0;
        cyc(2);
        check("blank_forces_black", pix(), 12'h000);
        bus.blank = 1'b1;
        cyc(1);
        check("unblank_after_1", pix(), 12'h000);
        cyc(1);
        check("unblank_after_2", pix(), 12'hFFF);

        pulse_req();
        check("busy_after_req", 12'(bus.fade_busy), fx(12'h001, 12'h000));
        tick(2);
        check("fade_L15", pix(), fx(12'hEEE, 12'hFFF));
        tick(8);
        pulse_req();
        tick(21);
        check("no_swap_before_32", 12'(swap_cnt), 12'h000);
        tick(1);
        check("swap_once_at_32", 12'(swap_cnt), fx(12'h001, 12'h000));
        check("black_pixel", pix(), fx(12'h000, 12'hFFF));
        tick(1);
        pulse_req();
        tick(2);
        check("still_black_hold", pix(), fx(12'h000, 12'hFFF));
        tick(4);
        check("fade_in_L2", pix(), fx(12'h111, 12'hFFF));
        tick(27);
        check("fade_in_L15", pix(), fx(12'hEEE, 12'hFFF));
        check("busy_before_end", 12'(bus.fade_busy), fx(12'h001, 12'h000));
        tick(1);
        check("idle_full", pix(), 12'hFFF);
        check("idle_busy", 12'(bus.fade_busy), 12'h000);
        check("swap_total", 12'(swap_cnt), fx(12'h001, 12'h000));

        pulse_req();
        tick(33);
        bus.bg_rgb = 12'hABC;
        #1 Reset = 1'b1;
        #1;
        check("reset_mid_pixel", pix(), 12'h000);
        check("reset_mid_busy", 12'(bus.fade_busy), 12'h000);
        swap_cnt = 0;
        cyc(1);
        Reset = 1'b0;
        cyc(3);
        check("after_reset_unscaled", pix(), 12'hABC);
        tick(40);
        check("after_reset_no_swap", 12'(swap_cnt), 12'h000);
        check("after_reset_idle", 12'(bus.fade_busy), 12'h000);

        bus.bg_rgb     = 12'hFFF;
        bus.fade_req   = 1'b1;
        bus.frame_tick = 1'b1;
        cyc(1);
        bus.fade_req   = 1'b0;
        bus.frame_tick = 1'b0;
        cyc(2);
        check("simul_L16", pix(), 12'hFFF);
        tick(1);
        check("simul_L16_1tick", pix(), 12'hFFF);
        tick(1);
        check("simul_L15_2ticks", pix(), fx(12'hEEE, 12'hFFF));
        cyc(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
